// File: rtl/feinv.sv
// feinv: field inverter for GF(2^255-19).
//   out = a^(p-2) mod p, computed by left-to-right square-and-multiply over
//   the fixed exponent e = 2^255-21. Each step goes through one femul instance,
//   for 254 squarings and 252 multiplies in total.
// Ports:
//   clock  in   1    rising-edge clock
//   reset  in   1    synchronous, active-high
//   start  in   1    request, sampled only while idle
//   a      in   255  operand, captured on an accepted start (any 255-bit value)
//   done   out  1    result valid; held until the next accepted start
//   out    out  255  result, stable while done is high
//
// femul: modular multiplier for GF(2^255-19), also used standalone.
//   Horner evaluation over three 85-bit digits of b, MSB first, with a fold
//   (2^255 == 19) after each step. The result is canonical (< p).
//   A start pulse captures a and b and abandons any work in flight. done drops
//   on that edge and rises 3 edges later, so done is first seen high 4 edges
//   after the start edge. out is held until the next start.
// Ports:
//   clock, reset  as above
//   start  in   1    one-cycle request
//   a, b   in   255  operands
//   done   out  1    product valid
//   out    out  255  product mod p

module femul (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);

    localparam int unsigned W     = 255;
    localparam int unsigned RW    = W + 1;          // partial result width
    localparam int unsigned CW    = 85;             // digit width of b
    localparam int unsigned NCH   = 3;              // digits per product
    localparam int unsigned PW    = RW + CW + 1;    // step sum width
    localparam int unsigned CNT_W = 2;
    localparam logic [W-1:0] P = {{250{1'b1}}, 5'b01101};

    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [RW-1:0]    r;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    logic [CW-1:0]    chunk_c;
    logic [PW-1:0]    sum_c;
    logic [RW-1:0]    fold_c;
    logic [RW-1:0]    red_c;
    logic [W-1:0]     canon_c;

    // One Horner step, plus the final reduction used on the last step.
    // The partial result stays below 2^256, so the sum stays below 2^342 and
    // a single fold brings it back below 2^256.
    always_comb begin
        chunk_c = '0;
        case (cnt)
            2'd0:    chunk_c = b_r[254:170];
            2'd1:    chunk_c = b_r[169:85];
            default: chunk_c = b_r[84:0];
        endcase
        sum_c   = {1'b0, r, {CW{1'b0}}} + (PW'(a_r) * PW'(chunk_c));
        fold_c  = RW'(sum_c[W-1:0]) + (RW'(sum_c[PW-1:W]) * RW'(19));
        // red_c < 2^255 + 19 < 2p, so one conditional subtract is enough.
        red_c   = RW'(fold_c[W-1:0]) + (fold_c[W] ? RW'(19) : RW'(0));
        canon_c = (red_c >= RW'(P)) ? W'(red_c - RW'(P)) : W'(red_c);
    end

    // Operand capture, step sequencing and result register.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            out  <= '0;
        end else if (start) begin
            a_r  <= a;
            b_r  <= b;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            r   <= fold_c;
            cnt <= cnt + 2'd1;
            if (cnt == CNT_W'(NCH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
                out  <= canon_c;
            end
        end
    end

endmodule

module feinv (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [254:0] a,
    output logic         done,
    output logic [254:0] out
);

    localparam int unsigned W   = 255;
    localparam int unsigned I_W = 8;
    // Low exponent bits e[4:0] = 01011. Every bit above 4 is one.
    localparam logic [7:0] E_LOW = 8'b0000_1011;

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        FINISH
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W-1:0]   x;
    logic [W-1:0]   x_d;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_d;
    logic [I_W-1:0] i;
    logic [I_W-1:0] i_d;
    logic           done_d;
    logic [W-1:0]   out_d;

    logic           e_bit_c;
    logic           mul_start_c;
    logic [W-1:0]   mul_b_c;
    logic           mul_done;
    logic [W-1:0]   mul_out;

    femul u_mul (
        .clock (clock),
        .reset (reset),
        .start (mul_start_c),
        .a     (acc),
        .b     (mul_b_c),
        .done  (mul_done),
        .out   (mul_out)
    );

    // Exponent bit at the current scan index.
    always_comb begin
        e_bit_c = (i > I_W'(4)) ? 1'b1 : E_LOW[i[2:0]];
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            x     <= '0;
            acc   <= '0;
            i     <= '0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_d;
            x     <= x_d;
            acc   <= acc_d;
            i     <= i_d;
            done  <= done_d;
            out   <= out_d;
        end
    end

    // Next-state, datapath updates and multiplier issue.
    always_comb begin
        state_d     = state;
        x_d         = x;
        acc_d       = acc;
        i_d         = i;
        done_d      = done;
        out_d       = out;
        mul_start_c = 1'b0;
        mul_b_c     = acc;

        case (state)
            IDLE: begin
                if (start) begin
                    // Bit 254 is handled by starting the accumulator at a.
                    x_d     = a;
                    acc_d   = a;
                    i_d     = I_W'(253);
                    done_d  = 1'b0;
                    state_d = SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                mul_start_c = 1'b1;
                state_d     = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_out;
                    if (e_bit_c) begin
                        state_d = MUL_ISSUE;
                    end else if (i == '0) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i - I_W'(1);
                        state_d = SQ_ISSUE;
                    end
                end
            end
            MUL_ISSUE: begin
                mul_start_c = 1'b1;
                mul_b_c     = x;
                state_d     = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_out;
                    if (i == '0) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i - I_W'(1);
                        state_d = SQ_ISSUE;
                    end
                end
            end
            FINISH: begin
                out_d   = acc;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_feinv.sv
// tb_feinv: directed and randomized checks of feinv against modular
// arithmetic done directly on 512-bit values inside the bench.
module tb_feinv;

    localparam logic [254:0] P      = {{250{1'b1}}, 5'b01101};
    localparam logic [254:0] P_M1   = {{250{1'b1}}, 5'b01100};
    localparam logic [254:0] P_P2   = {{250{1'b1}}, 5'b01111};
    localparam logic [254:0] INV2   = {1'b0, {250{1'b1}}, 4'b0111};
    // femul reports done 4 edges after its start edge.
    localparam int MUL_LAT = 4;
    // Counted from the edge that samples start (cycle 1) to the edge raising done.
    localparam int LAT     = 2 + 506 * (1 + MUL_LAT);
    localparam int TIMEOUT = LAT + 100;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [254:0] a;
    logic         done;
    logic [254:0] out;

    int checks   = 0;
    int failures = 0;

    feinv dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .done  (done),
        .out   (out)
    );

    always #5 clock = ~clock;

    function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
        logic [511:0] t;
        t = 512'(x) * 512'(y);
        t = t % 512'(P);
        return t[254:0];
    endfunction

    task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance a cycle at a time until done is high or the budget runs out.
    // Optionally pokes a one-cycle start with another operand at cycle poke_at.
    task automatic wait_done(input bit hold, input int poke_at, input logic [254:0] poke_val,
                             output int cyc);
        cyc = 0;
        while (cyc <= TIMEOUT) begin
            @(posedge clock);
            #1;
            cyc++;
            start = hold;
            if (poke_at != 0 && cyc == poke_at) begin
                a     = poke_val;
                start = 1'b1;
            end
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_inv(input logic [254:0] val, input bit hold, input int poke_at,
                           input logic [254:0] poke_val, output logic [254:0] res, output int cyc);
        a     = val;
        start = 1'b1;
        wait_done(hold, poke_at, poke_val, cyc);
        res = out;
    endtask

    initial begin
        logic [254:0] res;
        logic [254:0] v;
        logic [255:0] raw;
        int           cyc;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_done", 255'(done), 255'(0));
        check("reset_out", out, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // a = 1: exact latency, then result stays put while idle.
        run_inv(255'(1), 1'b0, 0, '0, res, cyc);
        check("lat_one", 255'(cyc), 255'(LAT));
        check("inv_one", res, 255'(1));
        a = 255'(12345);
        repeat (4) @(posedge clock);
        #1;
        check("hold_done", 255'(done), 255'(1));
        check("hold_out", out, 255'(1));

        run_inv(255'(2), 1'b0, 0, '0, res, cyc);
        check("lat_two", 255'(cyc), 255'(LAT));
        check("inv_two", res, INV2);

        run_inv(P_M1, 1'b0, 0, '0, res, cyc);
        check("inv_pm1", res, P_M1);

        run_inv('0, 1'b0, 0, '0, res, cyc);
        check("inv_zero", res, '0);

        // Non-canonical operand p+2 behaves as 2.
        run_inv(P_P2, 1'b0, 0, '0, res, cyc);
        check("inv_pp2", res, INV2);

        for (int n = 0; n < 20; n++) begin
            raw = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            v = (raw[254:0] % (P - 255'(1))) + 255'(1);
            run_inv(v, 1'b0, 0, '0, res, cyc);
            check("rand_lat", 255'(cyc), 255'(LAT));
            check("rand_inv", mulmod(v, res), 255'(1));
            a = ~v;
            @(posedge clock);
            #1;
            check("rand_hold", out, res);
        end

        // A start pulse with a = 5 mid-operation must be ignored.
        run_inv(255'(3), 1'b0, 500, 255'(5), res, cyc);
        check("poke_lat", 255'(cyc), 255'(LAT));
        check("poke_inv", mulmod(255'(3), res), 255'(1));

        // start held high: back-to-back inversions, each at full latency.
        run_inv(255'(7), 1'b1, 0, '0, res, cyc);
        check("b2b_lat0", 255'(cyc), 255'(LAT));
        check("b2b_inv0", mulmod(255'(7), res), 255'(1));
        a = 255'(11);
        wait_done(1'b1, 0, '0, cyc);
        start = 1'b0;
        res   = out;
        check("b2b_lat1", 255'(cyc), 255'(LAT));
        check("b2b_inv1", mulmod(255'(11), res), 255'(1));
        @(posedge clock);
        #1;
        check("b2b_idle", 255'(done), 255'(1));

        // Reset 1000 cycles into an inversion.
        a     = 255'(9);
        start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_done", 255'(done), 255'(0));
        check("abort_out", out, '0);
        reset = 1'b0;
        run_inv(255'(2), 1'b0, 0, '0, res, cyc);
        check("post_lat", 255'(cyc), 255'(LAT));
        check("post_inv", res, INV2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
